pcl_3w_slave: RTL

- Responder end of the team's 3-wire serial protocol.
- Decodes frames issued by the 3-wire master over tw_clock / tw_cs / tw_data and turns them into single-cycle register write/read strokes on a local parallel bus.
- Drives read data back on the shared data line.
- Sits in the in_clk domain; all 3-wire inputs are treated as asynchronous and oversampled.

---
 rtl/pcl_3w_slave.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pcl_3w_slave.sv
// 3-wire protocol responder: decodes serial frames into single-cycle register write/read strokes.
// Latency: strobes about SYNC_STAGES+1 in_clk after the sampling tw rise; no backpressure, master paces the frame.
// Optional trailing even-parity bit when PCL_3WS_PARITY_EN is defined.
module pcl_3w_slave #(
   parameter int PCL_3WS_ADDRESS_BITS = 7,
   parameter int PCL_3WS_DATA_BITS    = 8,
   parameter int PCL_3WS_SYNC_STAGES  = 2
) (
   input  logic                            in_clk,
   input  logic                            in_rst,
   input  logic                            in_tw_clock,
   input  logic                            in_tw_cs,
   inout  wire                             io_tw_data,
   output logic                            out_tw_dir,
   output logic [PCL_3WS_ADDRESS_BITS-1:0] out_reg_addr,
   output logic                            out_reg_wr,
   output logic [PCL_3WS_DATA_BITS-1:0]    out_reg_wr_data,
   output logic                            out_reg_rd,
   input  logic [PCL_3WS_DATA_BITS-1:0]    in_reg_rd_data,
   output logic                            out_frame_done,
   output logic                            out_parity_err
);

   localparam int AW = PCL_3WS_ADDRESS_BITS;
   localparam int DW = PCL_3WS_DATA_BITS;
   localparam int NS = PCL_3WS_SYNC_STAGES;
`ifdef PCL_3WS_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int CW = $clog2(1 + AW + DW + 1);
   localparam int SW = (AW > DW) ? AW : DW;

   // bit_cnt value while the named bit is being sampled (R/W bit is count 0)
   localparam logic [CW-1:0] LAST_ADDR = CW'(AW);
`ifdef PCL_3WS_PARITY_EN
   localparam logic [CW-1:0] PAR_BIT   = CW'(AW + DW + 1);
`else
   localparam logic [CW-1:0] LAST_DATA = CW'(AW + DW);
`endif
   localparam logic [CW-1:0] TOT       = CW'(1 + AW + DW + PB);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CMD     = 3'd1;
   localparam logic [2:0] ADDR    = 3'd2;
   localparam logic [2:0] RD_DATA = 3'd3;
   localparam logic [2:0] WR_DATA = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]    state;
   logic [NS-1:0] clk_s, cs_s, dat_s;
   logic [CW-1:0] bit_cnt, bit_cnt_inc;
   logic [SW-1:0] rx_shift;
   logic [DW-1:0] tx_shift;
   logic          rw, tx_bit, rd_cap, par_q;
   logic          tw_rise, tw_fall, cs_rise, cs_fall, d;

   assign tw_rise     = clk_s[NS-2] & ~clk_s[NS-1];
   assign tw_fall     = ~clk_s[NS-2] & clk_s[NS-1];
   assign cs_rise     = cs_s[NS-2] & ~cs_s[NS-1];
   assign cs_fall     = ~cs_s[NS-2] & cs_s[NS-1];
   assign d           = dat_s[NS-1];
   assign bit_cnt_inc = (bit_cnt == '1) ? bit_cnt : bit_cnt + CW'(1);
   assign io_tw_data  = out_tw_dir ? tx_bit : 1'bz;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state           <= IDLE;
         clk_s           <= '0;
         cs_s            <= '0;
         dat_s           <= '0;
         bit_cnt         <= '0;
         rx_shift        <= '0;
         tx_shift        <= '0;
         rw              <= 1'b0;
         tx_bit          <= 1'b0;
         rd_cap          <= 1'b0;
         par_q           <= 1'b0;
         out_tw_dir      <= 1'b0;
         out_reg_addr    <= '0;
         out_reg_wr      <= 1'b0;
         out_reg_wr_data <= '0;
         out_reg_rd      <= 1'b0;
         out_frame_done  <= 1'b0;
         out_parity_err  <= 1'b0;
      end else begin
         clk_s          <= {clk_s[NS-2:0], in_tw_clock};
         cs_s           <= {cs_s[NS-2:0], in_tw_cs};
         dat_s          <= {dat_s[NS-2:0], io_tw_data};
         out_reg_wr     <= 1'b0;
         out_reg_rd     <= 1'b0;
         out_frame_done <= 1'b0;
         out_parity_err <= 1'b0;
         // read data is registered by the bus one cycle after the request
         rd_cap         <= out_reg_rd;
         if (rd_cap) begin
            tx_shift <= in_reg_rd_data;
            par_q    <= rw ^ (^out_reg_addr) ^ (^in_reg_rd_data);
         end

         case (state)
            IDLE: begin
               if (cs_rise) begin
                  bit_cnt <= '0;
                  state   <= CMD;
               end
            end
            DONE: begin
               if (cs_fall) begin
                  out_frame_done <= 1'b1;
                  out_tw_dir     <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               if (cs_fall) begin
                  out_tw_dir <= 1'b0;
                  state      <= IDLE;
               end else begin
                  case (state)
                     CMD: if (tw_rise) begin
                        rw      <= d;
                        bit_cnt <= bit_cnt_inc;
                        state   <= ADDR;
                     end
                     ADDR: if (tw_rise) begin
                        rx_shift <= {rx_shift[SW-2:0], d};
                        bit_cnt  <= bit_cnt_inc;
                        if (bit_cnt == LAST_ADDR) begin
                           out_reg_addr <= {rx_shift[AW-2:0], d};
                           out_reg_rd   <= rw;
                           state        <= rw ? RD_DATA : WR_DATA;
                        end
                     end
                     RD_DATA: if (tw_fall) begin
                        if (bit_cnt < TOT) begin
                           out_tw_dir <= 1'b1;
                           tx_bit     <= tx_shift[DW-1];
                           tx_shift   <= {tx_shift[DW-2:0], par_q};
                           bit_cnt    <= bit_cnt_inc;
                        end else begin
                           out_tw_dir <= 1'b0;
                           state      <= DONE;
                        end
                     end
                     WR_DATA: if (tw_rise) begin
                        rx_shift <= {rx_shift[SW-2:0], d};
                        bit_cnt  <= bit_cnt_inc;
`ifdef PCL_3WS_PARITY_EN
                        if (bit_cnt == PAR_BIT) begin
                           if ((rw ^ (^out_reg_addr) ^ (^rx_shift[DW-1:0]) ^ d) == 1'b0) begin
                              out_reg_wr      <= 1'b1;
                              out_reg_wr_data <= rx_shift[DW-1:0];
                           end else begin
                              out_parity_err  <= 1'b1;
                           end
                           state <= DONE;
                        end
`else
                        if (bit_cnt == LAST_DATA) begin
                           out_reg_wr      <= 1'b1;
                           out_reg_wr_data <= {rx_shift[DW-2:0], d};
                           state           <= DONE;
                        end
`endif
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
